// File: rtl/riscv_lite_pkg.sv
// riscv_lite_pkg: shared writeback entry type and load funct3 encodings.
package riscv_lite_pkg;

    localparam int WB_XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order ring buffer of writeback entries with per-entry kill by rd match.
module wb_fifo
    import riscv_lite_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wb_entry_t                entry_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [4:0]               kill_rd_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     level_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_i && mem_q[i].rd == kill_rd_i) mem_q[i].valid <= 1'b0;
            if (push_i) mem_q[wr_q] <= entry_i;
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            level_q <= level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: sole register-file write port driver; LSU loads win, ALU results skid through wb_fifo.
// Define WB_LOAD_EXT_EN to extract and sign/zero-extend loads here; otherwise load words pass unchanged.
module wb_arbiter
    import riscv_lite_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = WB_XLEN
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [4:0]                    alu_rd_i,
    input  logic [XLEN-1:0]               alu_data_i,
    input  logic                          lsu_valid_i,
    input  logic [4:0]                    lsu_rd_i,
    input  logic [XLEN-1:0]               lsu_data_i,
    input  logic [2:0]                    lsu_funct3_i,
    input  logic [1:0]                    lsu_addr_lo_i,
    output logic                          reg_write_o,
    output logic [4:0]                    write_addr_o,
    output logic [XLEN-1:0]               data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o
);
    localparam int LVW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t       head, entry;
    logic [LVW-1:0]  level, level_nx;
    logic            empty, alu_acc, pop, direct, push, kill;
    logic [XLEN-1:0] ld_data, wdata;
    logic [4:0]      waddr;
    logic            we_d, we_q, ready_d, ready_q;
    logic [4:0]      addr_d, addr_q;
    logic [XLEN-1:0] data_d, data_q;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  lb;
    logic [15:0] lh;
    assign lb = lsu_data_i[{lsu_addr_lo_i, 3'b000} +: 8];
    assign lh = lsu_addr_lo_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
    always_comb
        ld_data = (lsu_funct3_i == LB)  ? {{(XLEN-8){lb[7]}}, lb} :
                  (lsu_funct3_i == LBU) ? {{(XLEN-8){1'b0}}, lb} :
                  (lsu_funct3_i == LH)  ? {{(XLEN-16){lh[15]}}, lh} :
                  (lsu_funct3_i == LHU) ? {{(XLEN-16){1'b0}}, lh} : lsu_data_i;
`else
    logic unused_ld;
    assign unused_ld = ^{lsu_funct3_i, lsu_addr_lo_i};
    assign ld_data   = lsu_data_i;
`endif

    assign empty   = (level == '0);
    assign alu_acc = alu_valid_i & ready_q;
    assign pop     = !lsu_valid_i & !empty;
    assign direct  = !lsu_valid_i & empty & alu_acc;
    assign push    = alu_acc & (|alu_rd_i) & !direct;
    assign kill    = lsu_valid_i & (|lsu_rd_i);
    // An ALU result losing to a same-rd load is already stale, so it enters the queue dead.
    assign entry   = '{valid: !(lsu_valid_i && lsu_rd_i == alu_rd_i), rd: alu_rd_i, data: alu_data_i};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .entry_i  (entry),
        .pop_i    (pop),
        .kill_i   (kill),
        .kill_rd_i(lsu_rd_i),
        .head_o   (head),
        .level_o  (level)
    );

    always_comb begin
        we_d     = lsu_valid_i ? |lsu_rd_i : !empty ? head.valid : direct & |alu_rd_i;
        waddr    = lsu_valid_i ? lsu_rd_i  : !empty ? head.rd    : alu_rd_i;
        wdata    = lsu_valid_i ? ld_data   : !empty ? head.data  : alu_data_i;
        addr_d   = we_d ? waddr : addr_q;
        data_d   = we_d ? wdata : data_q;
        level_nx = level + LVW'(push) - LVW'(pop);
        ready_d  = level_nx != LVW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign reg_write_o  = we_q;
    assign write_addr_o = addr_q;
    assign data_o       = data_q;
    assign alu_ready_o  = ready_q;
    assign fifo_level_o = level;
    assign busy_o       = we_q | !empty;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, reset corner sequence and randomized run against a queue model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0, lsu_rd_i = '0;
    logic [31:0] alu_data_i = '0, lsu_data_i = '0;
    logic [2:0]  lsu_funct3_i = 3'b010;
    logic [1:0]  lsu_addr_lo_i = '0;
    logic        alu_ready_o, reg_write_o, busy_o;
    logic [4:0]  write_addr_o;
    logic [31:0] data_o;
    logic [1:0]  fifo_level_o;

    int n_chk = 0, n_pass = 0;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_funct3_i(lsu_funct3_i), .lsu_addr_lo_i(lsu_addr_lo_i),
        .reg_write_o(reg_write_o), .write_addr_o(write_addr_o), .data_o(data_o),
        .fifo_level_o(fifo_level_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit av; logic [4:0] ar; logic [31:0] ad;
        bit lv; logic [4:0] lr; logic [31:0] ld; logic [2:0] f3; logic [1:0] lo;
        bit we; logic [4:0] a; logic [31:0] d; int lvl; bit rdy;
    } vec_t;
    vec_t tv[$];

    typedef struct { logic [4:0] rd; logic [31:0] d; bit dead; } ment_t;
    ment_t       mq[$];
    bit          ready_m, exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;

    function automatic logic [41:0] obs();
        return {reg_write_o, write_addr_o, data_o, fifo_level_o, busy_o, alu_ready_o};
    endfunction

    function automatic logic [41:0] pack(bit we, logic [4:0] a, logic [31:0] d, int lvl, bit rdy);
        return {we, a, d, 2'(lvl), we || lvl != 0, rdy};
    endfunction

    task automatic check(string nm, logic [41:0] act, logic [41:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (we,addr,data,level,busy,ready)", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit av, logic [4:0] ar, logic [31:0] ad, bit lv, logic [4:0] lr,
                         logic [31:0] ld, logic [2:0] f3, logic [1:0] lo);
        alu_valid_i = av; alu_rd_i = ar; alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = lr; lsu_data_i = ld; lsu_funct3_i = f3; lsu_addr_lo_i = lo;
    endtask

    function automatic logic [31:0] ext(logic [31:0] w, logic [2:0] f, logic [1:0] lo);
`ifdef WB_LOAD_EXT_EN
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
        if (f == 3'b000) return b[7] ? b | 32'hFFFFFF00 : b;
        if (f == 3'b100) return b;
        if (f == 3'b001) return h[15] ? h | 32'hFFFF0000 : h;
        if (f == 3'b101) return h;
        return w;
`else
        return (f == f && lo == lo) ? w : w;
`endif
    endfunction

    task automatic model_step();
        bit    acc, direct;
        ment_t h;
        acc = alu_valid_i && ready_m;
        direct = 1'b0;
        exp_we = 1'b0;
        if (lsu_valid_i) begin
            foreach (mq[i]) if (mq[i].rd == lsu_rd_i) mq[i].dead = 1'b1;
            if (lsu_rd_i != 0) begin
                exp_we = 1'b1; exp_a = lsu_rd_i; exp_d = ext(lsu_data_i, lsu_funct3_i, lsu_addr_lo_i);
            end
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (!h.dead) begin exp_we = 1'b1; exp_a = h.rd; exp_d = h.d; end
        end else if (acc) begin
            direct = 1'b1;
            if (alu_rd_i != 0) begin exp_we = 1'b1; exp_a = alu_rd_i; exp_d = alu_data_i; end
        end
        if (acc && alu_rd_i != 0 && !direct)
            mq.push_back('{alu_rd_i, alu_data_i, lsu_valid_i && lsu_rd_i == alu_rd_i});
        ready_m = mq.size() < DEPTH;
    endtask

    task automatic model_reset();
        mq.delete();
        ready_m = 1'b0; exp_we = 1'b0; exp_a = '0; exp_d = '0;
    endtask

    initial begin
        logic [31:0] lbv, lhuv, lhv;
`ifdef WB_LOAD_EXT_EN
        lbv = 32'hFFFFFF80; lhuv = 32'h000080FF; lhv = 32'hFFFF80FF;
`else
        lbv = 32'h80FF7F01; lhuv = 32'h80FF7F01; lhv = 32'h80FF7F01;
`endif
        tv.push_back('{1, 5'd5,  32'h1234, 0, 5'd0, 32'h0,  3'b010, 2'd0, 1, 5'd5,  32'h1234, 0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd5,  32'h1234, 0, 1});
        tv.push_back('{1, 5'd7,  32'h11,   1, 5'd6, 32'hAA, 3'b010, 2'd0, 1, 5'd6,  32'hAA,   1, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 1, 5'd7,  32'h11,   0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd7,  32'h11,   0, 1});
        tv.push_back('{1, 5'd9,  32'h1,    1, 5'd3, 32'h33, 3'b010, 2'd0, 1, 5'd3,  32'h33,   1, 1});
        tv.push_back('{0, 5'd0,  32'h0,    1, 5'd9, 32'h2,  3'b010, 2'd0, 1, 5'd9,  32'h2,    1, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd9,  32'h2,    0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd9,  32'h2,    0, 1});
        tv.push_back('{1, 5'd0,  32'hFF,   0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd9,  32'h2,    0, 1});
        tv.push_back('{1, 5'd10, 32'hA0,   1, 5'd1, 32'h10, 3'b010, 2'd0, 1, 5'd1,  32'h10,   1, 1});
        tv.push_back('{1, 5'd11, 32'hB0,   1, 5'd2, 32'h20, 3'b010, 2'd0, 1, 5'd2,  32'h20,   2, 0});
        tv.push_back('{1, 5'd12, 32'hC0,   1, 5'd3, 32'h30, 3'b010, 2'd0, 1, 5'd3,  32'h30,   2, 0});
        tv.push_back('{1, 5'd12, 32'hC0,   0, 5'd0, 32'h0,  3'b010, 2'd0, 1, 5'd10, 32'hA0,   1, 1});
        tv.push_back('{1, 5'd12, 32'hC0,   0, 5'd0, 32'h0,  3'b010, 2'd0, 1, 5'd11, 32'hB0,   1, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 1, 5'd12, 32'hC0,   0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd12, 32'hC0,   0, 1});
        tv.push_back('{1, 5'd8,  32'h77,   1, 5'd8, 32'h88, 3'b010, 2'd0, 1, 5'd8,  32'h88,   1, 1});
        tv.push_back('{0, 5'd0,  32'h0,    0, 5'd0, 32'h0,  3'b010, 2'd0, 0, 5'd8,  32'h88,   0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    1, 5'd0, 32'h55, 3'b010, 2'd0, 0, 5'd8,  32'h88,   0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    1, 5'd4, 32'h80FF7F01, 3'b000, 2'd3, 1, 5'd4, lbv,  0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    1, 5'd4, 32'h80FF7F01, 3'b101, 2'd2, 1, 5'd4, lhuv, 0, 1});
        tv.push_back('{0, 5'd0,  32'h0,    1, 5'd4, 32'h80FF7F01, 3'b001, 2'd2, 1, 5'd4, lhv,  0, 1});

        tick();
        check("reset_state", obs(), pack(0, 5'd0, 32'h0, 0, 0));
        rst_i = 1'b1;
        tick();
        check("post_reset_ready", obs(), pack(0, 5'd0, 32'h0, 0, 1));

        foreach (tv[i]) begin
            drive(tv[i].av, tv[i].ar, tv[i].ad, tv[i].lv, tv[i].lr, tv[i].ld, tv[i].f3, tv[i].lo);
            tick();
            check($sformatf("vec%0d", i), obs(), pack(tv[i].we, tv[i].a, tv[i].d, tv[i].lvl, tv[i].rdy));
        end

        drive(1, 5'd13, 32'hD0, 1, 5'd1, 32'h1, 3'b010, 2'd0);
        tick();
        drive(1, 5'd14, 32'hE0, 1, 5'd2, 32'h2, 3'b010, 2'd0);
        tick();
        check("two_queued", obs(), pack(1, 5'd2, 32'h2, 2, 0));
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 3'b010, 2'd0);
        rst_i = 1'b0;
        #1;
        check("async_reset", obs(), pack(0, 5'd0, 32'h0, 0, 0));
        tick();
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("after_reset%0d", i), obs(), pack(0, 5'd0, 32'h0, 0, 1));
        end

        rst_i = 1'b0;
        tick();
        model_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 15)), $urandom,
                  3'(($urandom_range(0, 4) == 0) ? 0 : ($urandom_range(0, 1) ? 3'b010 : 3'b101) ^
                     (($urandom_range(0, 1) != 0) ? 3'b000 : 3'b000)),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) lsu_funct3_i = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b001;
            model_step();
            tick();
            check($sformatf("rand%0d", i), obs(), pack(exp_we, exp_a, exp_d, mq.size(), ready_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
